// File: rtl/sc_input_debounce_pkg.sv
// Shared constants for the board input conditioner and its I/O map neighbours.
// Default widths, debounce length and data-memory I/O addresses.
package sc_input_debounce_pkg;

    localparam int SW_W_DEF      = 10;
    localparam int KEY_W_DEF     = 4;
    localparam int DB_CYCLES_DEF = 500000;
    localparam int CNT_W_DEF     = 19;

    typedef enum logic [1:0] {
        IO_SW  = 2'd0,
        IO_KEY = 2'd1,
        IO_HEX = 2'd2,
        IO_LED = 2'd3
    } io_sel_e;

    localparam logic [31:0] IO_ADDR_SW  = 32'h0000_FF00;
    localparam logic [31:0] IO_ADDR_KEY = 32'h0000_FF04;
    localparam logic [31:0] IO_ADDR_HEX = 32'h0000_FF08;
    localparam logic [31:0] IO_ADDR_LED = 32'h0000_FF0C;

endpackage

// File: rtl/sc_input_debounce_bit.sv
// One input bit: 2-FF synchroniser, optional inversion, stable-level filter.
// The counter filter exists only when INPUT_DEBOUNCE_EN is defined.
module debounce_bit
    import sc_input_debounce_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter bit INIT      = 1'b0,
    parameter bit INVERT    = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_acc
);

    logic r_meta;
    logic r_sync;
    logic w_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= INIT;
            r_sync <= INIT;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign w_s = r_sync ^ INVERT;

`ifdef INPUT_DEBOUNCE_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_q;
    logic             w_done;

    assign w_done = (r_cnt == CNT_W'(DB_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_q   <= 1'b0;
        end else if (w_s == r_q) begin
            r_cnt <= '0;
        end else if (w_done) begin
            r_q   <= w_s;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_q   = r_q;
    assign o_acc = (w_s != r_q) & w_done;
`else
    // Second sync stage doubles as the stable register.
    assign o_q   = w_s;
    assign o_acc = (r_meta ^ INVERT) != w_s;
`endif

endmodule

// File: rtl/sc_input_debounce.sv
// Switch/key conditioner feeding the data-memory I/O map.
// Define INPUT_DEBOUNCE_EN for the counter filter; otherwise sync only.
module sc_input_debounce
    import sc_input_debounce_pkg::*;
#(
    parameter int SW_W           = SW_W_DEF,
    parameter int KEY_W          = KEY_W_DEF,
    parameter int DB_CYCLES      = DB_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [SW_W-1:0]  sw_in,
    input  logic [KEY_W-1:0] key_in,
    input  logic [KEY_W-1:0] key_clr,
    output logic [SW_W-1:0]  sw_out,
    output logic [KEY_W-1:0] key_out,
    output logic [KEY_W-1:0] key_press,
    output logic             sw_changed
);

    logic [SW_W-1:0]  w_sw_q;
    logic [SW_W-1:0]  w_sw_acc;
    logic [KEY_W-1:0] w_key_q;
    logic [KEY_W-1:0] w_key_acc;
    logic [KEY_W-1:0] w_key_rise;
    logic [KEY_W-1:0] r_key_press;
    logic             r_sw_acc;
    logic             r_sw_changed;

    for (genvar g = 0; g < SW_W; g++) begin : g_sw
        debounce_bit #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W    (CNT_W),
            .INIT     (1'b0),
            .INVERT   (1'b0)
        ) u_bit (
            .i_clk(clock),
            .i_rst(reset),
            .i_d  (sw_in[g]),
            .o_q  (w_sw_q[g]),
            .o_acc(w_sw_acc[g])
        );
    end

    // Key sync FFs idle at the released pin level.
    for (genvar g = 0; g < KEY_W; g++) begin : g_key
        debounce_bit #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W    (CNT_W),
            .INIT     (KEY_ACTIVE_LOW),
            .INVERT   (KEY_ACTIVE_LOW)
        ) u_bit (
            .i_clk(clock),
            .i_rst(reset),
            .i_d  (key_in[g]),
            .o_q  (w_key_q[g]),
            .o_acc(w_key_acc[g])
        );
    end

    assign w_key_rise = w_key_acc & ~w_key_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_key_press  <= '0;
            r_sw_acc     <= 1'b0;
            r_sw_changed <= 1'b0;
        end else begin
            r_key_press  <= w_key_rise | (r_key_press & ~key_clr);
            r_sw_acc     <= |w_sw_acc;
            r_sw_changed <= r_sw_acc;
        end
    end

    assign sw_out     = w_sw_q;
    assign key_out    = w_key_q;
    assign key_press  = r_key_press;
    assign sw_changed = r_sw_changed;

endmodule
